// File: rtl/fifo_sync_pkg.sv
// Shared types and sizing helpers for the single-clock parametrised FIFO.
package fifo_sync_pkg;

    // Read-port behaviour: registered read or first-word-fall-through.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Occupancy and error status, decoded once and fanned out to ports.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Address width for a power-of-two depth (never below one bit).
    function automatic int fifo_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Counter width able to represent 0..depth inclusive.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
// A read and a write to the same slot in one cycle return the old word.
module fifo_sync_mem
    import fifo_sync_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write the accepted word into its slot; contents are intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with standard or fall-through read port,
// occupancy count, almost-full/empty thresholds, sticky error flags and flush.
module fifo_sync_param
    import fifo_sync_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_clear,
    input  logic                          i_push,
    input  logic [DATA_W-1:0]             i_data_in,
    input  logic                          i_pop,
    output logic [DATA_W-1:0]             o_data_out,
    output logic                          o_rd_valid,
    output logic                          o_full,
    output logic                          o_empty,
    output logic                          o_almost_full,
    output logic                          o_almost_empty,
    output logic [fifo_cnt_w(DEPTH)-1:0]  o_count,
    output logic                          o_overflow,
    output logic                          o_underflow
);

    localparam int         ADDR_W = fifo_addr_w(DEPTH);
    localparam int         CNT_W  = fifo_cnt_w(DEPTH);
    localparam int         PTR_W  = ADDR_W + 1;
    localparam fifo_mode_e MODE   = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_ptr_full;
    logic              w_ptr_empty;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic [DATA_W-1:0] w_mem_rd_data;
    fifo_status_t      w_status;

    assign w_ptr_empty = (r_wr_ptr == r_rd_ptr);
    assign w_ptr_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                         (r_wr_ptr[PTR_W-1]    != r_rd_ptr[PTR_W-1]);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
    assign w_pop_ok  = i_pop & ~w_ptr_empty;
    assign w_push_ok = i_push & (~w_ptr_full | w_pop_ok);

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer, count and sticky-flag state; reset and flush both empty the FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            if (i_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (i_pop && !w_pop_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    fifo_sync_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (w_push_ok),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (i_data_in),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_mem_rd_data)
    );

    // Status flags are pure decodes of the registered count.
    always_comb begin
        w_status              = '0;
        w_status.full         = (r_count == CNT_W'(DEPTH));
        w_status.empty        = (r_count == CNT_W'(0));
        w_status.almost_full  = (r_count >= CNT_W'(AF_THRESH));
        w_status.almost_empty = (r_count <= CNT_W'(AE_THRESH));
        w_status.overflow     = r_overflow;
        w_status.underflow    = r_underflow;
    end

    assign o_full         = w_status.full;
    assign o_empty        = w_status.empty;
    assign o_almost_full  = w_status.almost_full;
    assign o_almost_empty = w_status.almost_empty;
    assign o_overflow     = w_status.overflow;
    assign o_underflow    = w_status.underflow;
    assign o_count        = r_count;

    generate
        if (MODE == FIFO_FWFT) begin : gen_fwft
            // Head word is presented directly; zero while nothing is stored.
            assign o_rd_valid = ~w_status.empty;
            assign o_data_out = w_status.empty ? '0 : w_mem_rd_data;
        end else begin : gen_std
            logic [DATA_W-1:0] r_data_out;
            logic              r_rd_valid;

            // Registered read: word appears one cycle after an accepted pop.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_data_out <= '0;
                    r_rd_valid <= 1'b0;
                end else if (i_clear) begin
                    r_rd_valid <= 1'b0;
                end else if (w_pop_ok) begin
                    r_data_out <= w_mem_rd_data;
                    r_rd_valid <= 1'b1;
                end else begin
                    r_rd_valid <= 1'b0;
                end
            end

            assign o_data_out = r_data_out;
            assign o_rd_valid = r_rd_valid;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench: one standard-mode and one FWFT-mode FIFO share stimulus,
// both compared against a queue-based reference model.
module tb_fifo_sync_param;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] din = 8'h00;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_rdv, f_rdv, s_full, f_full, s_empty, f_empty;
    logic          s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_udf, f_udf;
    logic [3:0]    s_cnt, f_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] sb_std[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;
    bit            exp_zero = 1'b0;
    bit            mon_en = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_push(push), .i_data_in(din), .i_pop(pop),
        .o_data_out(s_dout), .o_rd_valid(s_rdv), .o_full(s_full), .o_empty(s_empty),
        .o_almost_full(s_af), .o_almost_empty(s_ae), .o_count(s_cnt),
        .o_overflow(s_ovf), .o_underflow(s_udf));

    fifo_sync_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_push(push), .i_data_in(din), .i_pop(pop),
        .o_data_out(f_dout), .o_rd_valid(f_rdv), .o_full(f_full), .o_empty(f_empty),
        .o_almost_full(f_af), .o_almost_empty(f_ae), .o_count(f_cnt),
        .o_overflow(f_ovf), .o_underflow(f_udf));

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue updated with the FIFO's acceptance rules.
    always @(posedge clk) begin
        bit pop_ok, push_ok;
        if (rst) begin
            q.delete(); sb_std.delete();
            m_ovf = 1'b0; m_udf = 1'b0; exp_zero = 1'b1;
        end else if (clear) begin
            q.delete(); sb_std.delete();
            m_ovf = 1'b0; m_udf = 1'b0; exp_zero = 1'b0;
        end else begin
            pop_ok  = pop && (q.size() != 0);
            push_ok = push && ((q.size() < DEPTH) || pop_ok);
            if (push && !push_ok) m_ovf = 1'b1;
            if (pop && !pop_ok)   m_udf = 1'b1;
            if (pop_ok) begin
                sb_std.push_back(q[0]);
                void'(q.pop_front());
            end
            if (push_ok) q.push_back(din);
            exp_zero = 1'b0;
        end
    end

    // Monitor: compares DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        int n;
        logic [DW-1:0] e;
        if (mon_en) begin
            n = q.size();
            chk("std_count", int'(s_cnt), n);
            chk("fwft_count", int'(f_cnt), n);
            chk("full", int'(s_full), int'(n == DEPTH));
            chk("empty", int'(s_empty), int'(n == 0));
            chk("almost_full", int'(s_af), int'(n >= AF));
            chk("almost_empty", int'(s_ae), int'(n <= AE));
            chk("overflow", int'(s_ovf), int'(m_ovf));
            chk("underflow", int'(s_udf), int'(m_udf));
            chk("fwft_flags", int'({f_full, f_empty, f_af, f_ae, f_ovf, f_udf}),
                int'({s_full, s_empty, s_af, s_ae, s_ovf, s_udf}) & 0 |
                int'({n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_udf}));
            // standard read port scoreboard
            if (s_rdv) begin
                if (sb_std.size() == 0) begin
                    chk("std_spurious_valid", 1, 0);
                end else begin
                    e = sb_std.pop_front();
                    chk("std_data", int'(s_dout), int'(e));
                end
            end else begin
                chk("std_missing_valid", int'(sb_std.size()), 0);
                sb_std.delete();
            end
            if (exp_zero) chk("std_dout_reset", int'(s_dout), 0);
            // fall-through port shows the model head
            chk("fwft_valid", int'(f_rdv), int'(n != 0));
            if (n != 0) chk("fwft_data", int'(f_dout), int'(q[0]));
        end
    end

    task automatic cyc(input bit ps, input bit pp, input logic [DW-1:0] d,
                       input bit cl = 1'b0, input bit rs = 1'b0);
        push = ps; pop = pp; din = d; clear = cl; rst = rs;
        @(posedge clk); #2;
        push = 1'b0; pop = 1'b0; clear = 1'b0; rst = 1'b0;
    endtask

    task automatic fill();
        for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, DW'(i));
    endtask

    initial begin
        // test 1: reset, fill, drain
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        mon_en = 1'b1;
        chk("reset_empty", int'(s_empty), 1);
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1'b1, 1'b0, DW'(i));
            chk("af_ramp", int'(s_af), int'(i >= AF));
        end
        chk("fill_full", int'(s_full), 1);
        chk("fill_count", int'(s_cnt), 8);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        chk("drain_empty", int'(s_empty), 1);

        // test 2: overflow on full push
        fill();
        cyc(1'b1, 1'b0, 8'hAA);
        chk("ovf_set", int'(s_ovf), 1);
        chk("ovf_count", int'(s_cnt), 8);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        // test 3: underflow, then flush clears it
        cyc(1'b0, 1'b1, 8'h00);
        chk("udf_set", int'(s_udf), 1);
        chk("udf_rdv", int'(s_rdv), 0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("udf_sticky", int'(s_udf), 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("udf_cleared", int'(s_udf), 0);
        chk("ovf_cleared", int'(s_ovf), 0);

        // test 4: full with simultaneous push and pop
        fill();
        cyc(1'b1, 1'b1, 8'h55);
        chk("fullpp_count", int'(s_cnt), 8);
        chk("fullpp_ovf", int'(s_ovf), 0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        // empty with push+pop: push kept, pop rejected
        cyc(1'b1, 1'b1, 8'h77);
        chk("emptypp_count", int'(s_cnt), 1);
        chk("emptypp_udf", int'(s_udf), 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // test 5: fall-through head visible before pop
        cyc(1'b1, 1'b0, 8'h3C);
        chk("fwft_head_valid", int'(f_rdv), 1);
        chk("fwft_head_data", int'(f_dout), 8'h3C);
        cyc(1'b0, 1'b1, 8'h00);
        chk("fwft_after_pop", int'(f_rdv), 0);
        cyc(1'b0, 1'b0, 8'h00);

        // test 6: long stream with wrap, reset mid-stream, fresh traffic
        for (int i = 0; i < 20; i++) cyc(1'b1, i >= 8, DW'(8'h80 + i));
        cyc(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
        chk("midrst_count", int'(s_cnt), 0);
        chk("midrst_empty", int'(s_empty), 1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, DW'(8'hC0 + i));
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        // randomized traffic with phase-biased push/pop rates
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = ((i / 60) % 2 == 0) ? 75 : 25;
            cyc($urandom_range(99) < bias, $urandom_range(99) >= bias - 10,
                DW'($urandom), $urandom_range(79) == 0, $urandom_range(199) == 0);
        end
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
